// File: rtl/rom_loader.sv
// rom_loader: assembles a byte stream into 16-bit words, writes them into the instruction ROM
// and releases the CPU when done. Define ROM_LOADER_CHECKSUM_EN to add the trailing checksum stage.
module rom_loader #(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH  = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   rom_wr_en,
    output logic [ADDR_WIDTH-1:0]  rom_wr_addr,
    output logic [INSTR_WIDTH-1:0] rom_wr_data,
    output logic                   cpu_resetN,
    output logic                   load_done,
    output logic                   load_error,
    output logic [ADDR_WIDTH:0]    words_loaded
);

    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
`ifdef ROM_LOADER_CHECKSUM_EN
        CHK_HI,
        CHK_LO,
`endif
        DONE,
        ERROR
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             hi_q, hi_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          words_q, words_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   rstn_q, rstn_d;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0]            sum_q, sum_d;
`endif
    logic [15:0]            rx_word;
    logic                   accept;

    always_comb begin
        rx_ready     = (state_q != DONE) && (state_q != ERROR);
        load_done    = (state_q == DONE);
        load_error   = (state_q == ERROR);
        rom_wr_en    = wr_en_q;
        rom_wr_addr  = wr_addr_q;
        rom_wr_data  = wr_data_q;
        cpu_resetN   = rstn_q;
        words_loaded = words_q;
    end

    always_comb begin
        rx_word = {hi_q, rx_data};
        accept  = rx_valid && rx_ready;
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        count_d   = count_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rstn_d    = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        // the counter trails word capture, so it equals the index of the word being received
        if (wr_en_q) begin
            words_d = words_q + CW'(1);
        end

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    count_d = CW'(rx_word);
`ifdef ROM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    if ({17'd0, rx_word} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (rx_word == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_d = CHK_HI;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = words_q[ADDR_WIDTH-1:0];
                    wr_data_d = rx_word;
`ifdef ROM_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + rx_word;
`endif
                    if (words_q + CW'(1) == count_q) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_d = CHK_HI;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CHK_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = CHK_LO;
                end
            end
            CHK_LO: begin
                if (accept) begin
                    state_d = (rx_word == sum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                rstn_d = 1'b1;
                if (load_start) begin
                    state_d = HDR_HI;
                    words_d = '0;
                    rstn_d  = 1'b0;
                end
            end
            ERROR: begin
                if (load_start) begin
                    state_d = HDR_HI;
                    words_d = '0;
                end
            end
            default: begin
                state_d = HDR_HI;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HDR_HI;
            hi_q      <= '0;
            count_q   <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rstn_q    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            count_q   <= count_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rstn_q    <= rstn_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed and random byte streams checked against a stream-parsing model.
// Honours ROM_LOADER_CHECKSUM_EN the same way the design does.
module tb_rom_loader;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rom_wr_en;
    logic [AW-1:0] rom_wr_addr;
    logic [15:0]   rom_wr_data;
    logic          cpu_resetN;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]    stim[$];
    logic [15:0]   words_in[$];
    logic [AW-1:0] obs_addr[$];
    logic [15:0]   obs_data[$];

    rom_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rom_wr_en    (rom_wr_en),
        .rom_wr_addr  (rom_wr_addr),
        .rom_wr_data  (rom_wr_data),
        .cpu_resetN   (cpu_resetN),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_wr_en === 1'b1) begin
            obs_addr.push_back(rom_wr_addr);
            obs_data.push_back(rom_wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, "_wr_en"}, 32'(rom_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(rom_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(rom_wr_data), 32'd0);
        chk({tag, "_cpu_resetN"}, 32'(cpu_resetN), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_error"}, 32'(load_error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acc);
        rx_data  = b;
        rx_valid = 1'b1;
        acc = (rx_ready === 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_restart(input string tag);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_error"}, 32'(load_error), 32'd0);
        chk({tag, "_cpu_resetN"}, 32'(cpu_resetN), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // builds count, words and (when compiled in) the checksum from words_in
    task automatic build_stream(input bit corrupt);
        logic [15:0] sum;
        logic [15:0] n;
        sum = 16'd0;
        n = 16'(words_in.size());
        stim = {};
        stim.push_back(n[15:8]);
        stim.push_back(n[7:0]);
        foreach (words_in[i]) begin
            stim.push_back(words_in[i][15:8]);
            stim.push_back(words_in[i][7:0]);
            sum = sum + words_in[i];
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        if (corrupt) sum = sum ^ 16'h0100;
        stim.push_back(sum[15:8]);
        stim.push_back(sum[7:0]);
`else
        if (corrupt) stim.push_back(8'h00);
`endif
    endtask

    task automatic run_load(input int gap_mode, input int ls_at, input string tag);
        logic [15:0] n;
        logic [15:0] sum;
        logic [15:0] exp_w[$];
        bit          exp_err;
        int          total;
        int          nacc;
        bit          acc;
        exp_w = {};
        exp_err = 1'b0;
        sum = 16'd0;
        nacc = 0;
        n = {stim[0], stim[1]};
        if (int'(n) > (1 << AW)) begin
            exp_err = 1'b1;
            total = 2;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp_w.push_back({stim[2 + 2 * i], stim[3 + 2 * i]});
                sum = sum + {stim[2 + 2 * i], stim[3 + 2 * i]};
            end
            total = 2 + 2 * int'(n);
`ifdef ROM_LOADER_CHECKSUM_EN
            exp_err = ({stim[total], stim[total + 1]} != sum);
            total = total + 2;
`endif
        end
        obs_addr = {};
        obs_data = {};
        for (int i = 0; i < total; i++) begin
            if (i == ls_at) begin
                load_start = 1'b1;
                @(negedge clk);
                load_start = 1'b0;
                chk({tag, "_ls_ignored"}, 32'(rx_ready), 32'd1);
            end
            if (i > 0) begin
                if (gap_mode == 1) @(negedge clk);
                else if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            send_byte(stim[i], acc);
            if (!acc) nacc++;
        end
        chk({tag, "_rejected"}, 32'(nacc), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'(!exp_err));
        chk({tag, "_error"}, 32'(load_error), 32'(exp_err));
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_rstn_early"}, 32'(cpu_resetN), 32'd0);
`ifndef ROM_LOADER_CHECKSUM_EN
        if (exp_w.size() > 0) begin
            chk({tag, "_last_wr_en"}, 32'(rom_wr_en), 32'd1);
            chk({tag, "_last_wr_addr"}, 32'(rom_wr_addr), 32'(exp_w.size() - 1));
            chk({tag, "_last_wr_data"}, 32'(rom_wr_data), 32'(exp_w[exp_w.size() - 1]));
        end
`endif
        @(negedge clk);
        chk({tag, "_rstn"}, 32'(cpu_resetN), 32'(!exp_err));
        chk({tag, "_wr_idle"}, 32'(rom_wr_en), 32'd0);
        @(negedge clk);
        chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < obs_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(obs_addr[i]), 32'(i));
            chk({tag, "_data"}, 32'(obs_data[i]), 32'(exp_w[i]));
        end
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_w.size()));
    endtask

    initial begin
        bit acc;
        reset = 1'b1;
        load_start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        #1;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        words_in = {16'h1234, 16'hABCD};
        build_stream(1'b0);
        run_load(0, -1, "basic");

        do_restart("rs_done");
        run_load(1, -1, "toggle");

        do_restart("rs2");
        run_load(0, 4, "ls_datahi");

`ifdef ROM_LOADER_CHECKSUM_EN
        do_restart("rs3");
        stim = {8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06};
        run_load(0, -1, "badsum");
`endif

        do_restart("rs4");
        stim = {8'hFF, 8'hFF};
        run_load(0, -1, "hdr_ovf");

        do_restart("rs_err");
        words_in = {};
        build_stream(1'b0);
        run_load(2, -1, "empty");

        do_restart("rs5");
        send_byte(8'h80, acc);
        send_byte(8'h00, acc);
        chk("max_n_error", 32'(load_error), 32'd0);
        chk("max_n_ready", 32'(rx_ready), 32'd1);
        apply_reset("rst_max");

        obs_addr = {};
        send_byte(8'h00, acc);
        send_byte(8'h02, acc);
        send_byte(8'h12, acc);
        apply_reset("rst_mid");
        repeat (2) @(negedge clk);
        chk("rst_mid_nowrite", 32'(obs_addr.size()), 32'd0);
        words_in = {16'h1234, 16'hABCD};
        build_stream(1'b0);
        run_load(0, -1, "after_rst");

        for (int t = 0; t < 8; t++) begin
            int nw;
            nw = $urandom_range(0, 6);
            words_in = {};
            for (int k = 0; k < nw; k++) words_in.push_back(16'($urandom));
            build_stream($urandom_range(0, 3) == 0);
            do_restart("rs_rand");
            run_load($urandom_range(0, 2), -1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 16, instruction word width; only 16 is supported (two bytes per word).
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, instruction ROM address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse that restarts a load from DONE or ERROR.
REQ-006 SHALL have port rx_data  input  8  incoming byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port rom_wr_en  output  1  instruction ROM write strobe.
REQ-010 SHALL have port rom_wr_addr  output  ADDR_WIDTH  ROM write address.
REQ-011 SHALL have port rom_wr_data  output  INSTR_WIDTH  ROM write data.
REQ-012 SHALL have port cpu_resetN  output  1  active-low hold for the downstream CPU.
REQ-013 SHALL have port load_done  output  1  load completed successfully.
REQ-014 SHALL have port load_error  output  1  load aborted.
REQ-015 SHALL have port words_loaded  output  ADDR_WIDTH+1  count of words written.

Function
REQ-016 SHALL accept a byte only on a rising edge where rx_valid and rx_ready are both 1.
REQ-017 SHALL use the stream format: count N (hi, lo), N words (hi, lo each), then optional checksum (hi, lo).
REQ-018 SHALL use states HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO, DONE, ERROR.
REQ-019 SHALL drive rx_ready 1 in HDR_HI through CHK_LO and 0 in DONE and ERROR.
REQ-020 SHALL go to ERROR when the received N exceeds 2**ADDR_WIDTH.
REQ-021 SHALL treat N=0 as an empty program: go from HDR_LO straight to the checksum stage, or to DONE when that stage is compiled out.
REQ-022 SHALL register the word {hi,lo} when the lo byte is accepted, and assert rom_wr_en for exactly one cycle in the cycle after that edge.
REQ-023 SHALL present rom_wr_addr = words_loaded and rom_wr_data = {hi,lo} during that rom_wr_en cycle, then increment words_loaded.
REQ-024 SHALL write the first word to address 0 and never wrap rom_wr_addr.
REQ-025 SHALL move to DONE on acceptance of the last required byte.
REQ-026 SHALL raise load_done on entry to DONE.
REQ-027 SHALL raise cpu_resetN one cycle after the final rom_wr_en pulse, or one cycle after DONE entry when N=0.
REQ-028 SHALL hold cpu_resetN at 0 in every state except DONE.
REQ-029 SHALL set load_error and leave rx_ready=0 in ERROR, with no further ROM writes.
REQ-030 SHALL respond to load_start in DONE or ERROR by returning to HDR_HI, clearing load_done, load_error and words_loaded, and driving cpu_resetN to 0 at the same edge.
REQ-031 SHALL ignore load_start in all other states.
REQ-032 SHALL keep the partially assembled word, with no timeout, when rx_valid drops mid-word.

Reset
REQ-033 SHALL, while reset is high and independent of clk, force state HDR_HI, rx_ready=1, rom_wr_en=0, rom_wr_addr=0, rom_wr_data=0, cpu_resetN=0, load_done=0, load_error=0, words_loaded=0.
REQ-034 SHALL on reset mid-load discard the partial word and issue no ROM write for it.

Configuration
REQ-035 SHALL provide the macro ROM_LOADER_CHECKSUM_EN to compile the checksum stage in or out.
REQ-036 SHALL, with ROM_LOADER_CHECKSUM_EN defined, accumulate the sum of all data words mod 2**16 and expect the checksum bytes after the last word; a match goes to DONE, a mismatch goes to ERROR with cpu_resetN kept 0.
REQ-037 SHALL, without ROM_LOADER_CHECKSUM_EN, omit CHK_HI and CHK_LO and the accumulator, making the last data lo byte the final byte.

Verification
REQ-038 SHALL cover: bytes 00 02 12 34 AB CD (+checksum BE 01 if enabled) -> writes 0x1234@0 and 0xABCD@1, load_done=1, words_loaded=2, cpu_resetN=1 one cycle after the second write.
REQ-039 SHALL cover: checksum enabled, bytes 00 01 00 05 00 06 -> load_error=1, cpu_resetN=0, rx_ready=0, one write performed.
REQ-040 SHALL cover: header FF FF with ADDR_WIDTH=15 -> ERROR after the second byte, no writes.
REQ-041 SHALL cover: rx_valid toggling 1/0 every cycle through the REQ-038 stream -> identical writes and result.
REQ-042 SHALL cover: reset pulse after bytes 00 02 12 -> all outputs at reset values, then a full REQ-038 stream loads correctly from address 0.
REQ-043 SHALL cover: load_start in DONE -> HDR_HI, cpu_resetN=0, load_done=0, words_loaded=0 at the same edge; load_start during DATA_HI has no effect.
